// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES-128 core.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] NR        = 4'd10;
    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1b;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? RCON_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Inverse as a^254 (maps 0 to 0), then the FIPS-197 affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = gmul(a, a);
        r  = sq;
        for (int i = 0; i < 6; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
                 ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step: derives the next round key from the current one.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] rk_in,
    input  logic [7:0]   rcon,
    output logic [127:0] rk_out
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;

    assign w0 = rk_in[127:96];
    assign w1 = rk_in[95:64];
    assign w2 = rk_in[63:32];
    assign w3 = rk_in[31:0];

    // SubWord(RotWord(w3)) with the round constant folded into the top byte
    assign t = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]),
                sbox(w3[7:0]), sbox(w3[31:24])};

    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign rk_out = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_round_dp.sv
// Single AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round_dp
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         final_round,
    output logic [127:0] state_out
);

    logic [127:0] sb, sr, mc;

    always_comb begin
        sb = '0;
        sr = '0;
        mc = '0;
        for (int i = 0; i < 16; i++) begin
            sb[127-8*i -: 8] = sbox(state_in[127-8*i -: 8]);
        end
        // byte i sits at row i%4, column i/4; row r rotates left by r
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[127-8*(r+4*c) -: 8] = sb[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            logic [7:0] a0, a1, a2, a3;
            a0 = sr[127-32*c -: 8];
            a1 = sr[119-32*c -: 8];
            a2 = sr[111-32*c -: 8];
            a3 = sr[103-32*c -: 8];
            mc[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            mc[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            mc[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            mc[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
    end

    assign state_out = (final_round ? sr : mc) ^ round_key;

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption controller: one round per clock, keys expanded on the fly.
module aes_round_ctrl
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic [3:0]   round_idx
);

    state_t       state;
    logic [127:0] state_reg;
    logic [127:0] rk_reg;
    logic [127:0] next_rk;
    logic [127:0] dp_out;
    logic [7:0]   rcon;
    logic [3:0]   round_cnt;
    logic         ready_q;
    logic         final_round;

    assign final_round = (round_cnt == NR);
    assign in_ready    = ready_q & rst_n;

    aes_key_step u_key_step (
        .rk_in  (rk_reg),
        .rcon   (rcon),
        .rk_out (next_rk)
    );

    aes_round_dp u_round_dp (
        .state_in    (state_reg),
        .round_key   (next_rk),
        .final_round (final_round),
        .state_out   (dp_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            state_reg <= '0;
            rk_reg    <= '0;
            rcon      <= RCON_INIT;
            round_cnt <= '0;
            ready_q   <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            round_idx <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        state     <= ROUND;
                        state_reg <= in_data ^ in_key;
                        rk_reg    <= in_key;
                        rcon      <= RCON_INIT;
                        round_cnt <= 4'd1;
                        ready_q   <= 1'b0;
                        busy      <= 1'b1;
                        round_idx <= 4'd1;
                    end
                end
                ROUND: begin
                    state_reg <= dp_out;
                    rk_reg    <= next_rk;
                    rcon      <= xtime(rcon);
                    if (final_round) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_data  <= dp_out;
                        round_idx <= NR;
                    end else begin
                        round_cnt <= round_cnt + 4'd1;
                        round_idx <= round_cnt + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        round_cnt <= '0;
                        ready_q   <= 1'b1;
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        busy      <= 1'b0;
                        round_idx <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: byte-level AES reference model, per-cycle output compare, FIPS vectors.
module tb_aes_round_ctrl;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
    logic [3:0]   round_idx;

    aes_round_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .round_idx (round_idx)
    );

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] RK10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sb_t [256];

    function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ ({8'h00, a} << i);
        for (int k = 15; k >= 8; k--)
            if (p[k]) p = p ^ (16'h011b << (k - 8));
        return p[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s, c;
        c = 8'h63;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (tb_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8]
                     ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sb_t[a] = s;
        end
    endtask

    function automatic logic [127:0] ref_aes(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        logic [7:0]  s [16];
        logic [7:0]  u [16];
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb_t[t[23:16]], sb_t[t[15:8]], sb_t[t[7:0]], sb_t[t[31:24]]}
                    ^ {rc, 24'h0};
                rc = tb_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sb_t[s[i]];
            for (int i = 0; i < 16; i++) u[i] = s[(i%4) + 4*(((i/4) + (i%4)) % 4)];
            for (int c = 0; c < 4; c++) begin
                if (r < 10) begin
                    s[4*c]   = tb_mul(u[4*c],8'h02) ^ tb_mul(u[4*c+1],8'h03) ^ u[4*c+2] ^ u[4*c+3];
                    s[4*c+1] = u[4*c] ^ tb_mul(u[4*c+1],8'h02) ^ tb_mul(u[4*c+2],8'h03) ^ u[4*c+3];
                    s[4*c+2] = u[4*c] ^ u[4*c+1] ^ tb_mul(u[4*c+2],8'h02) ^ tb_mul(u[4*c+3],8'h03);
                    s[4*c+3] = tb_mul(u[4*c],8'h03) ^ u[4*c+1] ^ u[4*c+2] ^ tb_mul(u[4*c+3],8'h02);
                end else begin
                    for (int k = 0; k < 4; k++) s[4*c+k] = u[4*c+k];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Cycle model: accept in idle, ciphertext 10 cycles later, held until taken.
    bit           m_busy = 0;
    bit           m_valid = 0;
    int           m_cnt = 0;
    logic [127:0] m_exp = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0;
            m_valid = 0;
            m_cnt = 0;
            m_exp = '0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy = 1;
                m_cnt = 0;
                m_exp = ref_aes(in_key, in_data);
            end
        end else if (!m_valid) begin
            m_cnt++;
            if (m_cnt == 10) m_valid = 1;
        end else if (out_ready) begin
            m_busy = 0;
            m_valid = 0;
        end
    end

    bit compare_on = 0;
    always @(negedge clk) begin
        if (compare_on) begin
            chk("cyc_in_ready", 128'(in_ready), 128'(rst_n && !m_busy));
            chk("cyc_out_valid", 128'(out_valid), 128'(m_valid));
            chk("cyc_out_data", out_data, m_valid ? m_exp : 128'h0);
            chk("cyc_busy", 128'(busy), 128'(m_busy));
            chk("cyc_round_idx", 128'(round_idx),
                128'(m_valid ? 10 : (m_busy ? m_cnt + 1 : 0)));
        end
    end

    logic [127:0] got_q [$];
    int           xfers = 0;
    always @(posedge clk) begin
        if (out_valid && out_ready) begin
            got_q.push_back(out_data);
            xfers++;
        end
    end

    // ---------------- stimulus ----------------
    int acc_cyc;
    int out_cyc;

    task automatic send(input logic [127:0] key, input logic [127:0] pt);
        bit ok;
        ok = 0;
        in_valid = 1'b1;
        in_key = key;
        in_data = pt;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (in_ready) begin
                @(posedge clk);
                ok = 1;
            end
            @(negedge clk);
        end
        acc_cyc = cyc;
        in_valid = 1'b0;
        chk("send_timeout", 128'(ok), 128'(1));
    endtask

    task automatic wait_out();
        bit ok;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (out_valid) ok = 1;
        end
        out_cyc = cyc;
        chk("out_timeout", 128'(ok), 128'(1));
    endtask

    int bad;
    int a1;
    int x0;
    logic [127:0] held;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_data = '0;
        in_key = '0;
        build_sbox();
        chk("model_app_b", ref_aes(KEY_B, PT_B), CT_B);
        chk("model_app_c1", ref_aes(KEY_C, PT_C), CT_C);
        compare_on = 1;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data", out_data, 128'h0);
        chk("rst_round_idx", 128'(round_idx), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 128'(in_ready), 128'(1));

        // App. B with sink always ready
        out_ready = 1'b1;
        send(KEY_B, PT_B);
        wait_out();
        chk("app_b_latency", 128'(out_cyc - acc_cyc), 128'(10));
        chk("app_b_ct", out_data, CT_B);
        chk("app_b_rk10", dut.rk_reg, RK10_B);
        @(negedge clk);

        // Idle with a stray out_ready pulse
        out_ready = 1'b0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            out_ready = (i == 25);
            @(negedge clk);
            if (busy !== 1'b0 || round_idx !== 4'd0 || out_valid !== 1'b0) bad++;
        end
        out_ready = 1'b0;
        chk("idle_quiet", 128'(bad), 128'(0));

        // Backpressure with App. C.1
        send(KEY_C, PT_C);
        wait_out();
        held = out_data;
        chk("bp_ct", held, CT_C);
        x0 = xfers;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 5) begin
                in_valid = 1'b1;
                in_data = ~in_data;
            end
            if (out_data !== held || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        chk("bp_stable", 128'(bad), 128'(0));
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 128'(out_valid), 128'(0));
        chk("bp_release_ready", 128'(in_ready), 128'(1));
        chk("bp_one_xfer", 128'(xfers - x0), 128'(1));

        // Back-to-back
        got_q.delete();
        send(KEY_B, PT_B);
        a1 = acc_cyc;
        send(KEY_C, PT_C);
        chk("b2b_spacing", 128'(acc_cyc - a1), 128'(12));
        wait_out();
        @(negedge clk);
        chk("b2b_count", 128'(got_q.size()), 128'(2));
        if (got_q.size() == 2) begin
            chk("b2b_first", got_q[0], CT_B);
            chk("b2b_second", got_q[1], CT_C);
        end

        // Reset mid-round
        in_valid = 1'b1;
        in_key = KEY_B;
        in_data = PT_B;
        bad = 1;
        for (int i = 0; i < 40 && bad != 0; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (round_idx == 4'd5) bad = 0;
        end
        chk("reach_round5", 128'(bad), 128'(0));
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 128'(out_valid), 128'(0));
        chk("midrst_out_data", out_data, 128'h0);
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_round_idx", 128'(round_idx), 128'(0));
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 128'(in_ready), 128'(1));
        chk("midrst_out_valid2", 128'(out_valid), 128'(0));
        send(KEY_B, PT_B);
        wait_out();
        chk("after_rst_ct", out_data, CT_B);
        @(negedge clk);
        @(negedge clk);

        compare_on = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Iterative AES-128 encryption controller. Sequences one instance of the single-round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey, with a final-round bypass of MixColumns) over 10 rounds, one round per clock.
- Performs the initial AddRoundKey and expands round keys on the fly.
- Has valid/ready handshakes on input and output, and sits between the bus-side block buffer and the ciphertext sink.

Parameters:
- NR, 10, number of rounds; fixed for AES-128, other values unsupported.

Ports:
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  plaintext and key are valid
- in_ready  output  1  controller can accept a block
- in_data  input  128  plaintext; byte 0 in [127:120], column-major (FIPS-197 order)
- in_key  input  128  cipher key, same byte order
- out_valid  output  1  ciphertext is valid
- out_ready  input  1  sink accepts ciphertext
- out_data  output  128  ciphertext
- busy  output  1  high in ROUND or DONE
- round_idx  output  4  current round number, 0 when idle

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, state_reg=0, rk_reg=0, rcon=8'h01, round_cnt=0. Outputs: in_ready=1 (deasserted while rst_n low), out_valid=0, out_data=0, busy=0, round_idx=0.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: state_reg<=in_data^in_key; rk_reg<=in_key; rcon<=8'h01; round_cnt<=1; go to ROUND.
  - in_data and in_key are sampled only on the handshake edge. Later input changes are ignored.
- ROUND:
  - next_rk=key_step(rk_reg,rcon), computed combinationally.
  - The datapath takes state_reg, round_key=next_rk, final_round=(round_cnt==NR).
  - Register updates: state_reg<=datapath output; rk_reg<=next_rk; rcon<=xtime(rcon) (0x80 becomes 0x1b); round_cnt<=round_cnt+1.
  - When round_cnt==NR, go to DONE instead of incrementing.
- DONE:
  - out_valid=1; out_data=state_reg.
  - out_data is held stable while out_valid&&!out_ready, for unbounded backpressure.
  - On out_ready: go to IDLE, out_valid=0 next cycle, round_cnt<=0.
- Ready rules: in_ready=0 in ROUND and DONE. There is no accept-while-draining; in_valid is ignored outside IDLE.
- Latency and throughput:
  - A handshake at edge T gives out_valid=1 after edge T+NR, i.e. 10 cycles.
  - Minimum block period is 12 cycles with out_ready held high.
- out_data: equals state_reg only in DONE, and is 0 otherwise. Intermediate round state never leaks.
- round_idx = round_cnt in ROUND, NR in DONE, 0 in IDLE.
- Key step (AES-128):
  - w0'=w0^SubWord(RotWord(w3))^{rcon,24'h0}; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
  - w0 = rk[127:96].
- Widths: round_cnt is 4 bits and never exceeds NR. rcon is 8 bits.
- Reset mid-operation: asserting rst_n low in any state aborts immediately and asynchronously. All outputs take reset values and no partial ciphertext is presented.
- Simultaneous events:
  - in_valid during DONE has no effect.
  - out_ready asserted outside DONE has no effect.

Decomposition:
- Shared package aes_pkg:
  - state type encodings (IDLE/ROUND/DONE)
  - NR=10, RCON_INIT=8'h01, RCON_POLY=8'h1b
  - xtime and the S-box function, reused by the datapath's SubBytes
- One sub-module: aes_key_step. It is combinational, with ports (rk_in 128, rcon 8, rk_out 128), and uses 4 S-box lookups.
- The controller instantiates aes_key_step and the existing round datapath.

Test Plan:
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, out_ready=1 -> out_data=3925841d02dc09fbdc118597196a0b32 with out_valid exactly 10 cycles after the handshake. The internal round-10 key equals d014f9a8c9ee2589e13f0cc8b6630ca6.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> out_data is stable, in_ready=0 throughout, and a change to in_data is ignored. Release -> one transfer, then in_ready=1 the next cycle.
- Back-to-back: present the App. B and App. C.1 vectors continuously with out_ready=1 -> both ciphertexts are correct and in order, with accept-to-accept spacing of 12 cycles.
- Reset mid-round: pulse rst_n low at round_idx=5 -> out_valid=0, out_data=0 and in_ready=1 after release. A following App. B block then produces the correct ciphertext.
- Idle: in_valid=0 for 50 cycles -> busy=0, round_idx=0, out_valid=0 constantly. A stray out_ready pulse causes no state change.
